// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// SEQ_MULT_ACC_EN (optional) enables the accumulate mode in the top.
package seq_mult_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W = $clog2(WIDTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth add/sub on the guarded accumulator.
// Same signed add/sub function as the upstream datapath.
module booth_step #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] m_i,
  input  logic [1:0]   sel_i,
  output logic [W-1:0] a_o
);

  always_comb begin
    unique case (sel_i)
      2'b01:   a_o = a_i + m_i;
      2'b10:   a_o = a_i - m_i;
      default: a_o = a_i;
    endcase
  end

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth signed multiplier, one step per clock.
// Define SEQ_MULT_ACC_EN for the accumulate / sticky overflow mode.
module seq_booth_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_ACC_EN
  input  logic               acc,
  output logic               ovf,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam int PW = 2 * WIDTH;

  state_e          state_q;
  logic [WIDTH:0]  m_q, a_q, sum, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic            qm1_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, done_q;
  logic [PW-1:0]   prod_q, prod_d, step_p;

  booth_step #(.W(WIDTH + 1)) u_step (
    .a_i   (a_q),
    .m_i   (m_q),
    .sel_i ({q_q[0], qm1_q}),
    .a_o   (sum)
  );

  // Arithmetic shift of {A,Q,q-1}; step_p is the product after this step.
  always_comb begin
    a_d    = {sum[WIDTH], sum[WIDTH:1]};
    q_d    = {sum[0], q_q[WIDTH-1:1]};
    step_p = {a_d[WIDTH-1:0], q_d};
  end

`ifdef SEQ_MULT_ACC_EN
  logic          acc_q, ovf_q, add_ovf;
  logic [PW-1:0] acc_sum;

  always_comb begin
    acc_sum = prod_q + step_p;
    add_ovf = (prod_q[PW-1] == step_p[PW-1]) &&
              (acc_sum[PW-1] != prod_q[PW-1]);
    prod_d  = acc_q ? acc_sum : step_p;
  end

  assign ovf = ovf_q;
`else
  always_comb prod_d = step_p;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
`ifdef SEQ_MULT_ACC_EN
      acc_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          qm1_q <= q_q[0];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            prod_q  <= prod_d;
`ifdef SEQ_MULT_ACC_EN
            if (acc_q) ovf_q <= ovf_q | add_ovf;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            m_q     <= {a[WIDTH-1], a};
            a_q     <= '0;
            q_q     <= b;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SEQ_MULT_ACC_EN
            acc_q   <= acc;
            if (!acc) ovf_q <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed bench for seq_booth_mult with a product scoreboard.
// Accumulate checks compile in when SEQ_MULT_ACC_EN is defined.
module tb_seq_booth_mult;

  logic        clk, rst, start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;
`ifdef SEQ_MULT_ACC_EN
  logic        acc, ovf;
`endif

  int tests = 0;
  int failed = 0;

  logic [16:0] sb[$];
  logic [15:0] mprev;
  logic        movf;

  seq_booth_mult #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
`ifdef SEQ_MULT_ACC_EN
    .acc     (acc),
    .ovf     (ovf),
`endif
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] x, input logic [7:0] y,
                          input logic ac);
    int xi, yi;
    logic [15:0] p, s;
    xi = $signed(x);
    yi = $signed(y);
    p = 16'(xi * yi);
    if (ac) begin
      s = mprev + p;
      if (mprev[15] == p[15] && s[15] != mprev[15]) movf = 1'b1;
    end else begin
      s = p;
      movf = 1'b0;
    end
    mprev = s;
    sb.push_back({movf, s});
  endtask

  task automatic drive(input logic [7:0] x, input logic [7:0] y,
                       input logic ac);
    start = 1'b1;
    a = x;
    b = y;
`ifdef SEQ_MULT_ACC_EN
    acc = ac;
`endif
    push_exp(x, y, ac);
  endtask

  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        input logic ac);
    int n;
    @(negedge clk);
    drive(x, y, ac);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 8);
  endtask

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'd0, done}, 0);
      end else begin
        e = sb.pop_front();
        check("product", {16'd0, product}, {16'd0, e[15:0]});
`ifdef SEQ_MULT_ACC_EN
        check("ovf", {31'd0, ovf}, {31'd0, e[16]});
`endif
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef SEQ_MULT_ACC_EN
    acc = 1'b0;
`endif
    mprev = '0;
    movf = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_product", {16'd0, product}, 0);
    rst = 1'b0;

    // 3 * 5: busy for 8 cycles, done at E0+8, low at E0+9
    @(negedge clk);
    drive(8'd3, 8'd5, 1'b0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t1_busy", {31'd0, busy}, 1);
      check("t1_done_lo", {31'd0, done}, 0);
      @(negedge clk);
    end
    check("t1_done", {31'd0, done}, 1);
    check("t1_busy_lo", {31'd0, busy}, 0);
    check("t1_prod", {16'd0, product}, 32'h000F);
    @(negedge clk);
    check("t1_done_clr", {31'd0, done}, 0);

    // sign corners
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'hFF, 8'd127, 1'b0);
    run_op(8'd0, -8'sd77, 1'b0);
    check("t2_prod", {16'd0, product}, 32'h0000);

    // start held high through RUN with changing operands
    @(negedge clk);
    drive(8'd9, 8'd9, 1'b0);
    @(negedge clk);
    a = 8'd2;
    b = 8'd2;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t3_latency", n, 8);
    check("t3_prod", {16'd0, product}, 32'h0051);
    push_exp(8'd2, 8'd2, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("t3_rerun", {31'd0, busy}, 1);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t3_latency2", n, 8);

    // abort 100 * 100 with reset mid-run
    @(negedge clk);
    start = 1'b1;
    a = 8'd100;
    b = 8'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t4_busy", {31'd0, busy}, 0);
    check("t4_done", {31'd0, done}, 0);
    check("t4_prod", {16'd0, product}, 0);
    mprev = '0;
    movf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    check("t4_no_done", n, 0);

    // back-to-back: 6*7 then -6*7 started at E0+9
    @(negedge clk);
    drive(8'd6, 8'd7, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("t5_done_early", {31'd0, done}, 0);
    @(negedge clk);
    check("t5_done1", {31'd0, done}, 1);
    drive(-8'sd6, 8'd7, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("t5_busy2", {31'd0, busy}, 1);
    check("t5_done_clr", {31'd0, done}, 0);
    repeat (7) @(negedge clk);
    check("t5_done_early2", {31'd0, done}, 0);
    @(negedge clk);
    check("t5_done2", {31'd0, done}, 1);
    check("t5_prod2", {16'd0, product}, 32'hFFD6);

    // a few pseudo-random pairs
    for (int i = 0; i < 6; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    end

`ifdef SEQ_MULT_ACC_EN
    run_op(8'd100, 8'd100, 1'b0);
    run_op(8'd100, 8'd100, 1'b1);
    check("t6_prod2", {16'd0, product}, 32'd20000);
    run_op(8'd100, 8'd100, 1'b1);
    run_op(8'd100, 8'd100, 1'b1);
    check("t6_prod4", {16'd0, product}, 32'h9C40);
    check("t6_ovf", {31'd0, ovf}, 1);
    @(negedge clk);
    drive(8'd1, 8'd1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("t6_ovf_clr", {31'd0, ovf}, 0);
    repeat (10) @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
